// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Generic inter-stage pipeline register with valid/ready
//            handshake, synchronous flush, optional 2-entry skid buffer
//            and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 36,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main (visible) entry
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  // Skid entry (only populated in the skid configuration)
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Datapath controls produced by the selected flow-control variant
  logic              load_in;
  logic              load_skid_to_main;
  logic              clear_main;

  logic              accept;
  logic              emit;
  logic [CNT_W-1:0]  stall_cnt;

  assign accept = i_valid & o_ready;
  assign emit   = main_valid & i_ready;

  generate
    if (SKID != 0) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_FULL  = 2'd1;
      localparam logic [1:0] ST_SKID  = 2'd2;

      logic [1:0] state;
      logic [1:0] next_state;
      logic       ready_q;
      logic       capture_skid;

      // State register; ready is registered so it never depends on i_ready
      always_ff @(posedge clk) begin
        if (rst) begin
          state   <= ST_EMPTY;
          ready_q <= 1'b1;
        end else begin
          state   <= next_state;
          ready_q <= (next_state != ST_SKID);
        end
      end

      // Next-state logic; flush empties both entries
      always_comb begin
        next_state = state;
        if (flush) begin
          next_state = ST_EMPTY;
        end else begin
          case (state)
            ST_EMPTY: if (accept) next_state = ST_FULL;
            ST_FULL: begin
              if (accept && !emit)      next_state = ST_SKID;
              else if (!accept && emit) next_state = ST_EMPTY;
            end
            ST_SKID:  if (emit) next_state = ST_FULL;
            default:  next_state = ST_EMPTY;
          endcase
        end
      end

      // Output decode: which register moves on this edge
      always_comb begin
        load_in           = 1'b0;
        load_skid_to_main = 1'b0;
        capture_skid      = 1'b0;
        clear_main        = 1'b0;
        if (!flush) begin
          case (state)
            ST_EMPTY: load_in = accept;
            ST_FULL: begin
              if (accept && emit) load_in      = 1'b1;
              else if (accept)    capture_skid = 1'b1;
              else if (emit)      clear_main   = 1'b1;
            end
            ST_SKID:  load_skid_to_main = emit;
            default:  ;
          endcase
        end
      end

      // Skid entry storage; emptiness is tracked by the state register
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (capture_skid) begin
          skid_ctrl <= i_ctrl;
          skid_data <= i_data;
        end
      end

      assign o_ready = ready_q;
    end else begin : g_single
      assign o_ready   = ~main_valid | i_ready;
      assign skid_ctrl = '0;
      assign skid_data = '0;

      // Single-entry flow control: load on accept, drain on emit
      always_comb begin
        load_in           = accept;
        load_skid_to_main = 1'b0;
        clear_main        = emit & ~accept;
      end
    end
  endgenerate

  // Main entry; control is zeroed whenever the slot becomes a bubble
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (load_in) begin
      main_valid <= 1'b1;
      main_ctrl  <= i_ctrl;
      main_data  <= i_data;
    end else if (load_skid_to_main) begin
      main_valid <= 1'b1;
      main_ctrl  <= skid_ctrl;
      main_data  <= skid_data;
    end else if (clear_main) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
    end
  end

  // Saturating count of cycles where the output is held by downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !i_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign o_valid     = main_valid;
  assign o_ctrl      = main_ctrl;
  assign o_data      = main_data;
  assign o_stall_cnt = stall_cnt;

endmodule
`default_nettype wire
